// File: rtl/branch_seq_ctrl.sv
// Branch sequencing controller for the fetch stage.
// Owns the fetch PC and arbitrates between branch-operand hazards, taken
// branches/jumps resolved in ID and instruction-memory wait states.
// Optional feature: define BR_DELAY_SLOT_EN to give taken branches a delay
// slot (the word fetched behind the branch is kept instead of squashed).
module branch_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [2:0]  cb,
  input  logic [31:0] new_pc,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  ex_wreg,
  input  logic        mem_memread,
  input  logic [4:0]  mem_wreg,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [31:0] stall_cnt
);

  // Branch-class encodings carried on cb.
  localparam logic [2:0] CB_J    = 3'd1;
  localparam logic [2:0] CB_BEQ  = 3'd2;
  localparam logic [2:0] CB_BNE  = 3'd3;
  localparam logic [2:0] CB_BGTZ = 3'd5;

`ifdef BR_DELAY_SLOT_EN
  localparam logic SQUASH_ON_TAKEN = 1'b0;
`else
  localparam logic SQUASH_ON_TAKEN = 1'b1;
`endif

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HAZ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] target_q, target_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        br;
  logic        jmp;
  logic        uses_rt;
  logic        rs_match;
  logic        rt_match;
  logic        hazard;
  logic        taken;
  logic [31:0] fall_pc;
  logic [31:0] seq_pc;
  logic        ifid_we_c;
  logic        ifid_flush_c;
  logic        idex_bubble_c;

  // A load in EX also raises ex_regwrite, so ex_memread adds no information
  // to the hazard check; it is kept on the port list for the pipeline's sake.
  logic unused_ex_memread;
  assign unused_ex_memread = ex_memread;

  // Decode the ID-stage instruction into branch class, hazard and taken.
  always_comb begin
    br       = 1'b0;
    jmp      = 1'b0;
    uses_rt  = 1'b0;
    rs_match = 1'b0;
    rt_match = 1'b0;
    hazard   = 1'b0;
    taken    = 1'b0;
    fall_pc  = id_pc + 32'd4;
    seq_pc   = pc_q + 32'd4;

    br      = id_valid && (cb >= CB_BEQ) && (cb <= CB_BGTZ);
    jmp     = id_valid && (cb == CB_J);
    uses_rt = (cb == CB_BEQ) || (cb == CB_BNE);

    rs_match = (id_rs != 5'd0) &&
               ((ex_regwrite && (ex_wreg == id_rs)) ||
                (mem_memread && (mem_wreg == id_rs)));
    rt_match = uses_rt && (id_rt != 5'd0) &&
               ((ex_regwrite && (ex_wreg == id_rt)) ||
                (mem_memread && (mem_wreg == id_rt)));

    hazard = br && (rs_match || rt_match);
    taken  = (br || jmp) && !hazard && (new_pc != fall_pc);
  end

  // Next-state, next-PC and pipeline-control outputs; HAZ re-runs the RUN
  // decision as soon as the hazard clears, including the imem_ready check.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    target_d      = target_q;
    ifid_we_c     = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;

    case (state_q)
      RUN, HAZ: begin
        if (hazard) begin
          state_d       = HAZ;
          idex_bubble_c = 1'b1;
        end else if (imem_ready) begin
          state_d      = RUN;
          pc_d         = taken ? new_pc : seq_pc;
          ifid_we_c    = 1'b1;
          ifid_flush_c = taken && SQUASH_ON_TAKEN;
        end else begin
          state_d      = WAIT;
          ifid_flush_c = 1'b1;
          if (taken) begin
            pend_d   = 1'b1;
            target_d = new_pc;
          end
        end
      end

      WAIT: begin
        if (imem_ready) begin
          state_d      = RUN;
          pc_d         = pend_q ? target_q : seq_pc;
          pend_d       = 1'b0;
          ifid_we_c    = 1'b1;
          ifid_flush_c = pend_q && SQUASH_ON_TAKEN;
        end else begin
          ifid_flush_c = 1'b1;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Count every cycle spent stalled in HAZ or WAIT, holding at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == HAZ || state_q == WAIT) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State, PC, pending-target and stall-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      target_q    <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      target_q    <= target_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // While reset is held the pipeline is kept frozen and empty.
  always_comb begin
    pc          = pc_q;
    stall_cnt   = stall_cnt_q;
    ifid_we     = !rst && ifid_we_c;
    ifid_flush  = rst || ifid_flush_c;
    idex_bubble = rst || idex_bubble_c;
  end

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Directed testbench for branch_seq_ctrl with hand-computed expectations.
// Build with BR_DELAY_SLOT_EN defined to check the delay-slot variant.
module tb_branch_seq_ctrl;

`ifdef BR_DELAY_SLOT_EN
  localparam logic [31:0] SQ = 32'd0;
`else
  localparam logic [31:0] SQ = 32'd1;
`endif

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [2:0]  cb;
  logic [31:0] new_pc;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_regwrite;
  logic        ex_memread;
  logic [4:0]  ex_wreg;
  logic        mem_memread;
  logic [4:0]  mem_wreg;
  logic        imem_ready;
  logic [31:0] pc;
  logic        ifid_we;
  logic        ifid_flush;
  logic        idex_bubble;
  logic [31:0] stall_cnt;

  int errorCount = 0;
  int checkCount = 0;

  branch_seq_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .cb(cb), .new_pc(new_pc),
    .id_rs(id_rs), .id_rt(id_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_wreg(ex_wreg),
    .mem_memread(mem_memread), .mem_wreg(mem_wreg),
    .imem_ready(imem_ready),
    .pc(pc), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .stall_cnt(stall_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single point of comparison for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive the ID-stage instruction and imem_ready.
  task automatic applyStimulus(input logic v, input logic [2:0] c, input logic [31:0] ipc,
                               input logic [31:0] npc, input logic [4:0] rs,
                               input logic [4:0] rt, input logic rdy);
    id_valid   = v;
    cb         = c;
    id_pc      = ipc;
    new_pc     = npc;
    id_rs      = rs;
    id_rt      = rt;
    imem_ready = rdy;
  endtask

  // Drive the EX/MEM producer signals.
  task automatic setProducers(input logic exrw, input logic [4:0] exw,
                              input logic memrd, input logic [4:0] memw);
    ex_regwrite = exrw;
    ex_memread  = 1'b0;
    ex_wreg     = exw;
    mem_memread = memrd;
    mem_wreg    = memw;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Short asynchronous reset pulse between clock edges.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    setProducers(1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    setProducers(1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);

    // Held in reset across an edge.
    #12;
    checkOutput("rst_pc", pc, 32'h3000);
    checkOutput("rst_we", {31'd0, ifid_we}, 32'd0);
    checkOutput("rst_flush", {31'd0, ifid_flush}, 32'd1);
    checkOutput("rst_bubble", {31'd0, idex_bubble}, 32'd1);
    checkOutput("rst_stall", stall_cnt, 32'd0);
    rst = 1'b0;

    // Sequential fetch.
    #1;
    checkOutput("seq_we", {31'd0, ifid_we}, 32'd1);
    checkOutput("seq_flush", {31'd0, ifid_flush}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      nextCycle();
      checkOutput("seq_pc", pc, 32'h3000 + 32'(4 * i));
    end
    checkOutput("seq_stall", stall_cnt, 32'd0);

    // One-cycle EX hazard on rs, then a taken beq.
    doReset();
    setProducers(1'b1, 5'd5, 1'b0, 5'd0);
    applyStimulus(1'b1, 3'd2, 32'h2FFC, 32'h3040, 5'd5, 5'd6, 1'b1);
    #1;
    checkOutput("haz_bubble", {31'd0, idex_bubble}, 32'd1);
    checkOutput("haz_we", {31'd0, ifid_we}, 32'd0);
    nextCycle();
    checkOutput("haz_pc_hold", pc, 32'h3000);
    setProducers(1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checkOutput("haz_exit_bubble", {31'd0, idex_bubble}, 32'd0);
    checkOutput("haz_exit_we", {31'd0, ifid_we}, 32'd1);
    checkOutput("haz_exit_flush", {31'd0, ifid_flush}, SQ);
    nextCycle();
    checkOutput("haz_pc_target", pc, 32'h3040);
    checkOutput("haz_stall", stall_cnt, 32'd1);

    // Register 0 never matches; bne resolves without a stall.
    doReset();
    setProducers(1'b1, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b1, 3'd3, 32'h3000, 32'h3080, 5'd7, 5'd0, 1'b1);
    #1;
    checkOutput("r0_bubble", {31'd0, idex_bubble}, 32'd0);
    nextCycle();
    checkOutput("r0_pc", pc, 32'h3080);
    checkOutput("r0_stall", stall_cnt, 32'd0);

    // blez ignores rt; new_pc equal to wrapped id_pc+4 is not taken.
    setProducers(1'b1, 5'd5, 1'b0, 5'd0);
    applyStimulus(1'b1, 3'd4, 32'hFFFF_FFFC, 32'h0000_0000, 5'd3, 5'd5, 1'b1);
    #1;
    checkOutput("wrap_bubble", {31'd0, idex_bubble}, 32'd0);
    checkOutput("wrap_flush", {31'd0, ifid_flush}, 32'd0);
    nextCycle();
    checkOutput("wrap_pc", pc, 32'h3084);

    // Taken jump while imem stalls two cycles; a second taken in WAIT is ignored.
    doReset();
    applyStimulus(1'b1, 3'd1, 32'h2FFC, 32'h3100, 5'd0, 5'd0, 1'b0);
    #1;
    checkOutput("jw_flush", {31'd0, ifid_flush}, 32'd1);
    checkOutput("jw_we", {31'd0, ifid_we}, 32'd0);
    nextCycle();
    checkOutput("jw_pc_hold1", pc, 32'h3000);
    applyStimulus(1'b1, 3'd1, 32'h2FFC, 32'h3500, 5'd0, 5'd0, 1'b0);
    #1;
    checkOutput("jw_wait_flush", {31'd0, ifid_flush}, 32'd1);
    nextCycle();
    checkOutput("jw_pc_hold2", pc, 32'h3000);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    #1;
    checkOutput("jw_ready_we", {31'd0, ifid_we}, 32'd1);
    checkOutput("jw_ready_flush", {31'd0, ifid_flush}, SQ);
    nextCycle();
    checkOutput("jw_pc_target", pc, 32'h3100);
    checkOutput("jw_stall", stall_cnt, 32'd2);

    // Taken beq with imem ready: squash depends on build, PC does not.
    doReset();
    applyStimulus(1'b1, 3'd2, 32'h2FFC, 32'h3200, 5'd1, 5'd2, 1'b1);
    #1;
    checkOutput("beq_flush", {31'd0, ifid_flush}, SQ);
    nextCycle();
    checkOutput("beq_pc", pc, 32'h3200);

    // MEM-load hazard together with imem stall: HAZ wins, then WAIT.
    doReset();
    setProducers(1'b0, 5'd0, 1'b1, 5'd9);
    applyStimulus(1'b1, 3'd5, 32'h2FFC, 32'h3400, 5'd9, 5'd0, 1'b0);
    #1;
    checkOutput("pri_bubble", {31'd0, idex_bubble}, 32'd1);
    checkOutput("pri_flush", {31'd0, ifid_flush}, 32'd0);
    nextCycle();
    checkOutput("pri_stall0", stall_cnt, 32'd0);
    nextCycle();
    checkOutput("pri_stall1", stall_cnt, 32'd1);
    checkOutput("pri_pc_hold", pc, 32'h3000);
    setProducers(1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checkOutput("pri_exit_flush", {31'd0, ifid_flush}, 32'd1);
    checkOutput("pri_exit_bubble", {31'd0, idex_bubble}, 32'd0);
    nextCycle();
    checkOutput("pri_stall2", stall_cnt, 32'd2);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    #1;
    checkOutput("pri_ready_flush", {31'd0, ifid_flush}, SQ);
    nextCycle();
    checkOutput("pri_pc_target", pc, 32'h3400);
    checkOutput("pri_stall3", stall_cnt, 32'd3);

    // Reset during WAIT drops the pending target.
    doReset();
    applyStimulus(1'b1, 3'd1, 32'h2FFC, 32'h3300, 5'd0, 5'd0, 1'b0);
    nextCycle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rw_pc_async", pc, 32'h3000);
    checkOutput("rw_stall_async", stall_cnt, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    #1;
    checkOutput("rw_flush", {31'd0, ifid_flush}, 32'd0);
    checkOutput("rw_we", {31'd0, ifid_we}, 32'd1);
    nextCycle();
    checkOutput("rw_pc_seq", pc, 32'h3004);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/branch_seq_ctrl.md
BRANCH_SEQ_CTRL -- requirements
Module: branch_seq_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000: fetch PC loaded on reset.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports id_valid in 1, id_pc in 32, cb in 3, new_pc in 32: ID-stage branch class and branch-unit next PC. cb encoding: 0 none, 1 j, 2 beq, 3 bne, 4 blez, 5 bgtz.
REQ-005 SHALL have ports id_rs in 5 and id_rt in 5: branch source registers.
REQ-006 SHALL have ports ex_regwrite in 1, ex_memread in 1, ex_wreg in 5, mem_memread in 1, mem_wreg in 5: producers in EX and MEM.
REQ-007 SHALL have port imem_ready in 1: instruction memory has returned the word at pc.
REQ-008 SHALL have outputs pc out 32 (fetch PC), ifid_we out 1, ifid_flush out 1, idex_bubble out 1, and stall_cnt out 32.

Function
REQ-009 SHALL use branch class br = id_valid & (cb>=2 & cb<=5); jmp = id_valid & cb==1.
REQ-010 SHALL assert hazard when br and a register matches (rs always; rt only for cb 2/3; register 0 never matches) under either condition: (ex_regwrite & ex_wreg match) or (mem_memread & mem_wreg match).
REQ-011 SHALL define taken = (br|jmp) & ~hazard & (new_pc != id_pc+4), with 32-bit wrap.
REQ-012 SHALL implement FSM states RUN, HAZ, WAIT.
REQ-013 RUN, hazard: go to HAZ; hold pc; ifid_we=0; idex_bubble=1.
REQ-014 HAZ: stay in HAZ while hazard; return to RUN the cycle hazard drops, evaluating the branch that same cycle as in RUN.
REQ-015 RUN, no hazard, imem_ready=1: pc <= taken ? new_pc : pc+4; ifid_we=1.
REQ-016 RUN, imem_ready=0: hold pc; ifid_we=0; ifid_flush=1 (bubble into ID). If taken that cycle, latch new_pc into a pending-target register and set pend=1. Go to WAIT.
REQ-017 WAIT: hold pc until imem_ready=1. On that cycle, pc <= pend ? target : pc+4; clear pend; return to RUN. A taken indication in WAIT is ignored, because ID is already bubbled.
REQ-018 When hazard and imem_ready=0 occur together, HAZ SHALL take priority; imem_ready SHALL be re-evaluated after leaving HAZ.
REQ-019 Taken-branch squash is governed by REQ-025/026.
REQ-020 stall_cnt SHALL increment by 1 in every cycle spent in HAZ or WAIT, and SHALL saturate at 32'hFFFF_FFFF.
REQ-021 All outputs except pc and stall_cnt SHALL be combinational from state and inputs; pc, stall_cnt, pend, target and state SHALL be registered.

Reset
REQ-022 rst=1 SHALL asynchronously set pc=RESET_PC, state=RUN, pend=0, target=0, stall_cnt=0.
REQ-023 While rst=1, ifid_we=0, ifid_flush=1, idex_bubble=1.
REQ-024 Reset asserted mid-HAZ or mid-WAIT SHALL discard any pending target.

Configuration
REQ-025 Macro BR_DELAY_SLOT_EN defined: taken SHALL NOT assert ifid_flush; the instruction fetched at pc (the delay slot) proceeds.
REQ-026 Macro BR_DELAY_SLOT_EN undefined: taken in RUN with imem_ready=1 SHALL assert ifid_flush=1 in the same cycle, squashing the fall-through word.

Verification
REQ-027 Reset release, imem_ready=1, cb=0 for 3 cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; stall_cnt=0.
REQ-028 cb=2, id_rs=5, ex_regwrite=1, ex_wreg=5 for 1 cycle, then taken to 0x3040 -> one HAZ cycle (pc held, idex_bubble=1); next cycle pc=0x3040; stall_cnt=1.
REQ-029 cb=3, id_rt=0, ex_wreg=0, ex_regwrite=1 -> no hazard; branch resolves without stall.
REQ-030 Taken jmp to 0x3100 with imem_ready=0 for 2 cycles -> pc held 2 cycles, ifid_flush=1, then pc=0x3100; stall_cnt=2.
REQ-031 Taken beq to 0x3200, imem_ready=1 -> with BR_DELAY_SLOT_EN undefined, ifid_flush=1; with it defined, ifid_flush=0; pc=0x3200 in both builds.
REQ-032 rst pulsed during WAIT with a pending target -> pc=0x3000, pend cleared, and the pending target is never applied.
